// File: rtl/traffic_ctrl.sv
// traffic_ctrl: two-road intersection light sequencer with pedestrian crossing
module traffic_ctrl #(
  parameter int         CNT_W  = 4,
  parameter logic [2:0] MAIN_G = 3'b001
) (
  input  logic             clk,
  input  logic             g_reset,
  input  logic             tick,
  input  logic             sensor_sync,
  input  logic             walk_request,
  input  logic [CNT_W-1:0] value,
  output logic [1:0]       interval,
  output logic [2:0]       light_main,
  output logic [2:0]       light_side,
  output logic             walk_lamp,
  output logic             expired,
  output logic [2:0]       state
);
  localparam logic [2:0] LG = MAIN_G;
  localparam logic [2:0] LY = MAIN_G << 1;
  localparam logic [2:0] LR = MAIN_G << 2;
  localparam logic [CNT_W-1:0] ONE = 1;
  typedef enum logic [2:0] {S_MG, S_MGX, S_MY, S_WALK, S_SG, S_SGX, S_SY} state_t;
  typedef enum logic [1:0] {P_SEL, P_WAIT, P_RUN} phase_t;
  state_t cur, nxt;
  phase_t phase;
  logic [CNT_W-1:0] cnt;
  logic walk_pending, done;
  assign state = cur;
  assign done = phase == P_RUN && cnt == '0;
  // successor state, only taken on the expiry edge
  always_comb begin
    nxt = cur;
    case (cur)
      S_MG, S_MGX: nxt = (sensor_sync || walk_pending) ? S_MY : S_MGX;
      S_MY:        nxt = walk_pending ? S_WALK : S_SG;
      S_WALK:      nxt = S_SG;
      S_SG:        nxt = sensor_sync ? S_SGX : S_SY;
      S_SGX:       nxt = S_SY;
      default:     nxt = S_MG;
    endcase
  end
  // state, phase sequencing, down-counter, walk latch and registered lamps
  always_ff @(posedge clk or negedge g_reset) begin
    if (!g_reset) begin
      cur          <= S_MG;
      phase        <= P_SEL;
      cnt          <= '0;
      walk_pending <= 1'b0;
      interval     <= 2'b00;
      expired      <= 1'b0;
      light_main   <= LG;
      light_side   <= LR;
      walk_lamp    <= 1'b0;
    end else begin
      expired      <= done;
      walk_pending <= (done && nxt == S_WALK) ? 1'b0 :
                      (walk_request && cur != S_WALK) ? 1'b1 : walk_pending;
      if (done) begin
        cur        <= nxt;
        phase      <= P_SEL;
        interval   <= (nxt == S_MY || nxt == S_SY) ? 2'b10 :
                      (nxt == S_MGX || nxt == S_WALK || nxt == S_SGX) ? 2'b01 : 2'b00;
        light_main <= (nxt == S_MG || nxt == S_MGX) ? LG : nxt == S_MY ? LY : LR;
        light_side <= (nxt == S_SG || nxt == S_SGX) ? LG : nxt == S_SY ? LY : LR;
        walk_lamp  <= nxt == S_WALK;
      end else if (phase == P_SEL) begin
        phase <= P_WAIT;
      end else if (phase == P_WAIT) begin
        cnt   <= value;
        phase <= P_RUN;
      end else if (tick && cnt != '0) begin
        cnt <= cnt - ONE;
      end
    end
  end
endmodule

// File: tb/tb_traffic_ctrl.sv
// tb_traffic_ctrl: table-driven phase sequences checked cycle by cycle through a scoreboard
module tb_traffic_ctrl;
  localparam logic [2:0] MG = 3'd0, MGX = 3'd1, MY = 3'd2, WALK = 3'd3, SG = 3'd4, SGX = 3'd5, SY = 3'd6;
  logic clk = 1'b0, g_reset = 1'b0, tick = 1'b1, sensor_sync = 1'b0, walk_request = 1'b0;
  logic [3:0] value;
  logic [1:0] interval;
  logic [2:0] light_main, light_side, state;
  logic walk_lamp, expired;
  logic [3:0] base_v = 4'd6, ext_v = 4'd3, yel_v = 4'd2;
  int tests = 0, fails = 0;
  typedef struct packed {
    logic [2:0] st;
    logic [1:0] iv;
    logic [2:0] lm;
    logic [2:0] ls;
    logic       wl;
    logic       ex;
  } obs_t;
  typedef struct {
    bit         rst;
    logic [3:0] yel;
    bit         sensor;
    int         tdiv;
    int         walk_at;
    logic [2:0] st;
    int         n;
  } vec_t;
  obs_t q[$];
  vec_t v[$];
  always #5 clk = ~clk;
  traffic_ctrl #(.CNT_W(4), .MAIN_G(3'b001)) dut (
    .clk(clk), .g_reset(g_reset), .tick(tick), .sensor_sync(sensor_sync),
    .walk_request(walk_request), .value(value), .interval(interval),
    .light_main(light_main), .light_side(light_side), .walk_lamp(walk_lamp),
    .expired(expired), .state(state)
  );
  // stand-in for the timing-parameter block: one register of latency from interval
  always @(posedge clk or negedge g_reset)
    if (!g_reset) value <= '0;
    else value <= interval == 2'b00 ? base_v : interval == 2'b01 ? ext_v : yel_v;
  function automatic obs_t expect_of(logic [2:0] s, logic ex);
    obs_t o;
    o.st = s; o.ex = ex; o.wl = 1'b0; o.iv = 2'b00; o.lm = 3'b100; o.ls = 3'b100;
    case (s)
      MG:      o.lm = 3'b001;
      MGX:     begin o.lm = 3'b001; o.iv = 2'b01; end
      MY:      begin o.lm = 3'b010; o.iv = 2'b10; end
      WALK:    begin o.wl = 1'b1; o.iv = 2'b01; end
      SG:      o.ls = 3'b001;
      SGX:     begin o.ls = 3'b001; o.iv = 2'b01; end
      default: begin o.ls = 3'b010; o.iv = 2'b10; end
    endcase
    return o;
  endfunction
  function automatic void add(bit r, logic [3:0] y, bit s, int td, int wa, logic [2:0] st, int n);
    v.push_back('{r, y, s, td, wa, st, n});
  endfunction
  task automatic check(string name);
    obs_t e, g;
    e = q.pop_front();
    g = {state, interval, light_main, light_side, walk_lamp, expired};
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s: got st=%0d iv=%b main=%b side=%b walk=%b exp=%b, want st=%0d iv=%b main=%b side=%b walk=%b exp=%b",
               name, g.st, g.iv, g.lm, g.ls, g.wl, g.ex, e.st, e.iv, e.lm, e.ls, e.wl, e.ex);
    end
  endtask
  task automatic do_reset(int k);
    @(negedge clk);
    #2 g_reset = 1'b0;
    walk_request = 1'b0;
    #1 q.push_back(expect_of(MG, 1'b0));
    check($sformatf("reset_async_v%0d", k));
    @(negedge clk);
    @(negedge clk);
    g_reset = 1'b1;
  endtask
  initial begin
    // defaults, no sensor, no walk: MG then MGX reloading forever
    add(1, 2, 0, 1, -1, MG, 9);  add(0, 2, 0, 1, -1, MGX, 6); add(0, 2, 0, 1, -1, MGX, 6);
    // sensor held: full cycle back to MG
    add(1, 2, 1, 1, -1, MG, 9);  add(0, 2, 1, 1, -1, MY, 5);  add(0, 2, 1, 1, -1, SG, 9);
    add(0, 2, 1, 1, -1, SGX, 6); add(0, 2, 1, 1, -1, SY, 5);  add(0, 2, 1, 1, -1, MG, 9);
    // walk pulse in MG, second press in WALK dropped so the next MG falls into MGX
    add(1, 2, 0, 1, 3, MG, 9);   add(0, 2, 0, 1, -1, MY, 5);  add(0, 2, 0, 1, 2, WALK, 6);
    add(0, 2, 0, 1, -1, SG, 9);  add(0, 2, 0, 1, -1, SY, 5);  add(0, 2, 0, 1, -1, MG, 9);
    add(0, 2, 0, 1, -1, MGX, 6);
    // 1-in-4 tick in MY with value 2; the tick on the SEL edge is ignored
    add(1, 2, 1, 1, -1, MG, 9);  add(0, 2, 1, 4, -1, MY, 10); add(0, 2, 1, 1, -1, SG, 9);
    // zero-length yellow: 3 cycles each
    add(1, 0, 1, 1, -1, MG, 9);  add(0, 0, 1, 1, -1, MY, 3);  add(0, 0, 1, 1, -1, SG, 9);
    add(0, 0, 1, 1, -1, SGX, 6); add(0, 0, 1, 1, -1, SY, 3);  add(0, 0, 1, 1, -1, MG, 9);
    // reset in the middle of SGX, then a clean restart
    add(1, 2, 1, 1, -1, MG, 9);  add(0, 2, 1, 1, -1, MY, 5);  add(0, 2, 1, 1, -1, SG, 9);
    add(0, 2, 1, 1, -1, SGX, 3); add(1, 2, 1, 1, -1, MG, 9);  add(0, 2, 1, 1, -1, MY, 5);
    foreach (v[k]) begin
      yel_v = v[k].yel;
      sensor_sync = v[k].sensor;
      if (v[k].rst) do_reset(k);
      for (int i = 0; i < v[k].n; i++) q.push_back(expect_of(v[k].st, i == 0 && !v[k].rst));
      for (int i = 0; i < v[k].n; i++) begin
        check($sformatf("v%0d_st%0d_c%0d", k, v[k].st, i));
        tick = (i % v[k].tdiv) == 0;
        walk_request = i == v[k].walk_at;
        @(negedge clk);
      end
    end
    walk_request = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/traffic_ctrl.md
Name: traffic_ctrl

Overview:
Sequencer for the two-road intersection (main road / side road plus pedestrian crossing). It walks the light FSM and drives the `interval` select into the timing-parameter block. It loads the returned `value` into an internal down-counter and advances state when the count expires. It also latches pedestrian walk requests and uses `sensor_sync` to extend or cut green phases.

Parameters:
CNT_W, 4, width of `value` input and internal down-counter
MAIN_G, 3'b001, main-road green lamp code ({R,Y,G}); side/yellow/red codes follow same {R,Y,G} one-hot encoding

Ports:
clk  input  1  system clock, all state on rising edge
g_reset  input  1  asynchronous active-low reset, shared with timing-parameter block
tick  input  1  1-cycle timebase enable (1 Hz strobe); counter only decrements when high
sensor_sync  input  1  synchronised side-road vehicle sensor, level
walk_request  input  1  synchronised pedestrian button, level or pulse
value  input  CNT_W  duration returned by timing-parameter block (registered there, 1-cycle latency from `interval`)
interval  output  2  duration select: 00 base, 01 extended, 10 yellow; 11 never driven
light_main  output  3  main-road lamps {R,Y,G}, one-hot
light_side  output  3  side-road lamps {R,Y,G}, one-hot
walk_lamp  output  1  pedestrian walk lamp
expired  output  1  1-cycle pulse on the edge a state's count reaches zero and the FSM transitions
state  output  3  current FSM state, for debug/status

Behaviour:
- Reset (g_reset=0, async):
  - state=S_MG, phase=SEL, cnt=0, walk_pending=0, interval=00, expired=0.
  - light_main=001, light_side=100, walk_lamp=0.
  - Reset mid-state abandons the count. No partial phase is resumed.
- States, with interval select and lamps:
  - S_MG: 00; main G, side R.
  - S_MGX: 01; main G, side R.
  - S_MY: 10; main Y, side R.
  - S_WALK: 01; both R, walk_lamp=1.
  - S_SG: 00; main R, side G.
  - S_SGX: 01; main R, side G.
  - S_SY: 10; main R, side Y.
- Lamps and interval are registered and change on the same edge as `state`.
- Per-state phases. Edge E0 enters the state (phase SEL, `interval` updated).
  - E1: phase WAIT, covering the timing block's register latency.
  - E2: cnt<=value, phase RUN.
  - From E3 onward, in RUN: if tick=1 and cnt!=0, cnt decrements.
  - The first edge where phase=RUN and cnt==0 (pre-edge) is the expiry edge: the FSM takes its transition and `expired` pulses for 1 cycle.
  - With tick held high and value N, the state lasts exactly N+3 cycles. N=0 gives 3 cycles.
- `tick` during SEL/WAIT is ignored. No wrap-around: cnt never decrements below 0.
- Transitions at expiry:
  - S_MG: if sensor_sync or walk_pending, go to S_MY; else go to S_MGX.
  - S_MGX: if sensor_sync or walk_pending, go to S_MY; else re-enter S_MGX. A re-entry is a full reload through SEL/WAIT.
  - S_MY: if walk_pending, go to S_WALK; else go to S_SG.
  - S_WALK: go to S_SG.
  - S_SG: if sensor_sync, go to S_SGX; else go to S_SY.
  - S_SGX: go to S_SY.
  - S_SY: go to S_MG.
- sensor_sync and walk_pending are sampled only at the expiry edge.
- walk_pending:
  - Set on any cycle with walk_request=1 and state!=S_WALK.
  - Cleared on the edge entering S_WALK. If a request arrives on that same edge, clear wins.
  - Requests during S_WALK are dropped.
- A `value` change from reprogramming of the timing block mid-RUN has no effect until the next load.
- Main and side never show non-R simultaneously. Exactly one bit is set in each lamp vector at all times.

Test Plan:
- Defaults (base=6, ext=3, yel=2), tick=1, sensor=0, no walk → S_MG 9 cycles, then S_MGX repeating every 6 cycles; interval 00 then 01; main stays 001.
- sensor=1 from reset → S_MG(9), S_MY(5), S_SG(9), S_SGX(6), S_SY(5), S_MG. Lamps follow the table; expired pulses once per state.
- Walk pulse 1 cycle during S_MG, sensor=0 → S_MY then S_WALK (6 cycles, walk_lamp=1, both R) then S_SG. walk_pending clear after S_WALK entry; second press inside S_WALK ignored.
- tick toggling 1-in-4 with value=2 in S_MY → 2 decrements needed; transition on first edge after cnt hits 0. SEL/WAIT ticks not counted.
- value=0 for yellow → S_MY and S_SY each last exactly 3 cycles.
- Assert g_reset low mid-S_SGX → outputs return immediately (async) to the reset values; after release the full S_MG 9-cycle sequence restarts.
